// File: rtl/seq_mul_pkg.sv
// seq_mul_pkg: shared types and helpers for the sequential multiplier.
// Holds the controller state encoding and the step-counter width helper.
package seq_mul_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE   = 2'd0,
        LOAD_B = 2'd1,
        CALC   = 2'd2,
        DONE   = 2'd3
    } state_t;

    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/seq_mul_if.sv
// seq_mul_if: operand/result bus between a bus master and the multiplier.
// master drives start/data_in; slave returns busy/done/product.
interface seq_mul_if #(
    parameter int WIDTH = 16
);

    logic                 start;
    logic [WIDTH-1:0]     data_in;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;

    modport master (
        output start,
        output data_in,
        input  busy,
        input  done,
        input  product
    );

    modport slave (
        input  start,
        input  data_in,
        output busy,
        output done,
        output product
    );

endinterface

// File: rtl/seq_mul_ctrl.sv
// seq_mul_ctrl: IDLE/LOAD_B/CALC/DONE sequencer for the multiplier.
// Optional macro SEQ_MUL_SKIP_ZERO_EN: zero operand jumps LOAD_B -> DONE.
import seq_mul_pkg::*;

module seq_mul_ctrl (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic cnt_one,
    input  logic op_zero,
    output logic ld_a,
    output logic ld_b,
    output logic step,
    output logic fin,
    output logic skip,
    output logic busy,
    output logic done
);

`ifdef SEQ_MUL_SKIP_ZERO_EN
    localparam bit SKIP_EN = 1'b1;
`else
    localparam bit SKIP_EN = 1'b0;
`endif

    state_t state;

    assign ld_a = (state == IDLE) && start;
    assign ld_b = (state == LOAD_B);
    assign step = (state == CALC);
    assign fin  = step && cnt_one;
    assign skip = SKIP_EN && ld_b && op_zero;

    // State register with busy/done registered alongside the transitions
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= LOAD_B;
                        busy  <= 1'b1;
                    end
                end
                LOAD_B: begin
                    if (skip) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        state <= CALC;
                    end
                end
                CALC: begin
                    if (cnt_one) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/seq_mul_unit.sv
// seq_mul_unit: unsigned shift-and-add multiplier, one step per cycle.
// Optional macro SEQ_MUL_SKIP_ZERO_EN shortcuts zero operands.
import seq_mul_pkg::*;

module seq_mul_unit #(
    parameter int WIDTH = 16
) (
    input logic       clk,
    input logic       rst_n,
    seq_mul_if.slave  bus
);

    localparam int CW = cnt_w(WIDTH);

    logic [2*WIDTH-1:0] a_q;
    logic [WIDTH-1:0]   b_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] acc_next;
    logic [2*WIDTH-1:0] prod_q;
    logic [CW-1:0]      cnt_q;

    logic ld_a;
    logic ld_b;
    logic step;
    logic fin;
    logic skip;
    logic cnt_one;
    logic op_zero;
    logic busy;
    logic done;

    assign cnt_one  = (cnt_q == CW'(1));
    assign op_zero  = (a_q == '0) || (bus.data_in == '0);
    assign acc_next = b_q[0] ? (acc_q + a_q) : acc_q;

    seq_mul_ctrl u_ctrl (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (bus.start),
        .cnt_one (cnt_one),
        .op_zero (op_zero),
        .ld_a    (ld_a),
        .ld_b    (ld_b),
        .step    (step),
        .fin     (fin),
        .skip    (skip),
        .busy    (busy),
        .done    (done)
    );

    // Multiplicand and accumulator: load on start, shift/add per step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            acc_q <= '0;
        end else if (ld_a) begin
            a_q   <= {{WIDTH{1'b0}}, bus.data_in};
            acc_q <= '0;
        end else if (step) begin
            a_q   <= a_q << 1;
            acc_q <= acc_next;
        end
    end

    // Multiplier and step counter: load in LOAD_B, consume per step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_q   <= '0;
            cnt_q <= '0;
        end else if (ld_b) begin
            b_q   <= bus.data_in;
            cnt_q <= CW'(WIDTH);
        end else if (step) begin
            b_q   <= b_q >> 1;
            cnt_q <= cnt_q - CW'(1);
        end
    end

    // Result register only moves on the transition into DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_q <= '0;
        end else if (fin) begin
            prod_q <= acc_next;
        end else if (skip) begin
            prod_q <= '0;
        end
    end

    assign bus.busy    = busy;
    assign bus.done    = done;
    assign bus.product = prod_q;

endmodule

// File: tb/tb_seq_mul_unit.sv
// tb_seq_mul_unit: directed checks of the sequential multiplier.
// Covers W=16 and W=8 instances; zero-skip expectations follow the macro.
module tb_seq_mul_unit;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    seq_mul_if #(.WIDTH(16)) bus ();
    seq_mul_if #(.WIDTH(8))  bus8 ();

    seq_mul_unit #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    seq_mul_unit #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic run_op(
        input string       name,
        input logic [15:0] a,
        input logic [15:0] b,
        input int          exp_c,
        input logic [31:0] exp_p,
        input logic [31:0] prev_p,
        input int          extra,
        input int          p1,
        input int          p2
    );
        int done_n;
        int first;
        int bad_busy;
        int bad_prod;
        done_n   = 0;
        first    = -1;
        bad_busy = 0;
        bad_prod = 0;
        bus.start   = 1'b1;
        bus.data_in = a;
        for (int c = 1; c <= exp_c + extra; c++) begin
            @(negedge clk);
            bus.start   = (c == p1) || (c == p2);
            bus.data_in = (c == 1) ? b : 16'hA5A5;
            if (bus.done === 1'b1) begin
                done_n++;
                if (first < 0) first = c;
            end
            if (bus.busy !== logic'(c <= exp_c)) bad_busy++;
            if (c < exp_c && bus.product !== prev_p) bad_prod++;
            if (c >= exp_c && bus.product !== exp_p) bad_prod++;
        end
        checks++;
        if (first !== exp_c) begin
            failures++;
            $display("FAIL %s done_cycle got=%0d exp=%0d", name, first, exp_c);
        end
        checks++;
        if (done_n !== 1) begin
            failures++;
            $display("FAIL %s done_count got=%0d exp=1", name, done_n);
        end
        checks++;
        if (bad_busy !== 0) begin
            failures++;
            $display("FAIL %s busy_cycles wrong=%0d exp=0", name, bad_busy);
        end
        checks++;
        if (bad_prod !== 0) begin
            failures++;
            $display("FAIL %s product bad_cycles=%0d final=%h exp=%h",
                     name, bad_prod, bus.product, exp_p);
        end
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.data_in  = '0;
        bus8.start   = 1'b0;
        bus8.data_in = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL reset busy got=%b exp=0", bus.busy);
        end
        checks++;
        if (bus.done !== 1'b0) begin
            failures++;
            $display("FAIL reset done got=%b exp=0", bus.done);
        end
        checks++;
        if (bus.product !== 32'h0) begin
            failures++;
            $display("FAIL reset product got=%h exp=0", bus.product);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        run_op("basic_3x5", 16'd3, 16'd5, 18, 32'd15, 32'd0, 2, 0, 0);
    endtask

    task automatic test_max();
        run_op("max_ffff", 16'hFFFF, 16'hFFFF, 18, 32'hFFFE0001,
               32'd15, 2, 0, 0);
    endtask

    task automatic test_zero_operand();
`ifdef SEQ_MUL_SKIP_ZERO_EN
        run_op("zero_a", 16'd0, 16'd7, 2, 32'd0, 32'hFFFE0001, 2, 0, 0);
`else
        run_op("zero_a", 16'd0, 16'd7, 18, 32'd0, 32'hFFFE0001, 2, 0, 0);
`endif
    endtask

    task automatic test_back_to_back();
        run_op("ignore_start", 16'd9, 16'd4, 18, 32'd36, 32'd0, 0, 5, 18);
        @(negedge clk);
        run_op("b2b_next", 16'd12, 16'd11, 18, 32'd132, 32'd36, 2, 0, 0);
    endtask

    task automatic test_reset_mid();
        int done_n;
        int bad;
        done_n      = 0;
        bad         = 0;
        bus.start   = 1'b1;
        bus.data_in = 16'd5;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            bus.start   = 1'b0;
            bus.data_in = (c == 1) ? 16'd6 : 16'd0;
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL midreset busy got=%b exp=0", bus.busy);
        end
        checks++;
        if (bus.done !== 1'b0) begin
            failures++;
            $display("FAIL midreset done got=%b exp=0", bus.done);
        end
        checks++;
        if (bus.product !== 32'h0) begin
            failures++;
            $display("FAIL midreset product got=%h exp=0", bus.product);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (bus.done === 1'b1) done_n++;
            if (bus.busy !== 1'b0 || bus.product !== 32'h0) bad++;
        end
        checks++;
        if (done_n !== 0) begin
            failures++;
            $display("FAIL midreset stray_done got=%0d exp=0", done_n);
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL midreset idle_outputs bad=%0d exp=0", bad);
        end
    endtask

    task automatic test_width8();
        int first;
        int done_n;
        first        = -1;
        done_n       = 0;
        bus8.start   = 1'b1;
        bus8.data_in = 8'd200;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            bus8.start   = 1'b0;
            bus8.data_in = (c == 1) ? 8'd100 : 8'h5A;
            if (bus8.done === 1'b1) begin
                done_n++;
                if (first < 0) first = c;
                checks++;
                if (bus8.product !== 16'd20000) begin
                    failures++;
                    $display("FAIL w8 product got=%0d exp=20000",
                             bus8.product);
                end
            end
        end
        checks++;
        if (first !== 10) begin
            failures++;
            $display("FAIL w8 done_cycle got=%0d exp=10", first);
        end
        checks++;
        if (done_n !== 1) begin
            failures++;
            $display("FAIL w8 done_count got=%0d exp=1", done_n);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_basic();
        test_max();
        test_zero_operand();
        test_back_to_back();
        test_width8();
        test_reset_mid();
        test_basic();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule
